uart_rx: RTL
============

Name: uart_rx

Overview:
Receive-side counterpart of the team's UART transmitter; it consumes the serial line that the TX top drives.
- Deserialises one frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit.
- Uses a fixed oversampling clock with majority-vote bit sampling.
- Presents the received word with a one-cycle valid strobe and one-cycle error strobes.
- Intended for loopback verification of the TX path and as the RX half of the UART top.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
OVERSAMPLE, 8, CLK cycles per bit; legal values 8, 16, 32

Ports:
CLK  input  1  oversampling clock, one tick per sample
RST  input  1  asynchronous, active-low reset
RX_IN  input  1  serial line, idle high
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
P_DATA  output  DATA_WIDTH  last correctly received word
DATA_VALID  output  1  one-cycle pulse, P_DATA updated this cycle
PAR_ERR  output  1  one-cycle pulse, parity mismatch on the frame just ended
STP_ERR  output  1  one-cycle pulse, stop bit sampled low

Behaviour:
- Reset (RST low, asynchronous):
  - state = IDLE; all counters = 0.
  - P_DATA = 0; DATA_VALID, PAR_ERR and STP_ERR = 0.
  - Both synchroniser flops = 1.
  - Reset mid-frame discards the partial frame with no strobe.
- RX_IN passes through a 2-flop synchroniser; all logic uses the synchronised value rx_s.
- edge_cnt runs 0..OVERSAMPLE-1 within each bit; bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling:
  - rx_s is captured at edge_cnt = OS/2-1, OS/2 and OS/2+1.
  - The majority of those three samples is the bit value, valid from edge_cnt = OS/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START: when rx_s = 0. That cycle is edge_cnt 0 of the start bit. PAR_EN and PAR_TYP are latched here and held for the whole frame.
  - START -> IDLE: glitch, when the sampled start value = 1. No strobe is raised.
  - START -> DATA: at edge_cnt = OS-1, when the start bit sampled 0.
  - DATA: the sampled bit shifts into the shift register LSB-first. At edge_cnt = OS-1 with bit_cnt = DATA_WIDTH-1, go to PARITY if the latched PAR_EN = 1, otherwise go to STOP.
  - PARITY: the sampled bit is compared with the XOR of the shift register (inverted when PAR_TYP = 1). At edge_cnt = OS-1, go to STOP.
  - STOP: at edge_cnt = OS-1, go to IDLE and raise strobes for one cycle:
    - DATA_VALID = 1 and P_DATA = shift register, only if there is no parity error and stop = 1;
    - otherwise PAR_ERR and/or STP_ERR = 1 (both may pulse together), and P_DATA holds its old value.
- Latency: from the first CLK edge that samples RX_IN low to the DATA_VALID cycle is 2 + N*OVERSAMPLE - 1 cycles, where N = DATA_WIDTH + 2 + PAR_EN.
  - For OS = 8, 8 data bits: 89 cycles with parity, 81 without.
- Back-to-back frames: a start bit that begins right after the stop bit is detected in the first IDLE cycle; no idle gap is required.
- PAR_EN or PAR_TYP changing mid-frame has no effect until the next start detection.
- A line held low forever: every frame ends with STP_ERR and the FSM re-enters START immediately. There is no lockup.

Decomposition:
- uart_pkg holds:
  - the FSM state enum (3-bit encoding);
  - localparams START_BIT = 0, STOP_BIT = 1, PAR_EVEN = 0, PAR_ODD = 1.
  - The TX and RX both import it.
- One sub-module, data_sampler: takes rx_s, edge_cnt and OVERSAMPLE; outputs the majority bit and a sample_done flag.
- The FSM, counters, shift register and parity checker stay in uart_rx.

Test Plan:
- 8E1, PAR_TYP = 0, byte 0xA5, parity bit 0, stop 1 -> DATA_VALID pulses exactly 89 cycles after the start edge; P_DATA = 0xA5; PAR_ERR = STP_ERR = 0.
- 8N1, PAR_EN = 0, byte 0x3C -> DATA_VALID at cycle 81; P_DATA = 0x3C.
- 8O1, byte 0x01, parity bit wrongly sent as 1 -> PAR_ERR pulses once; DATA_VALID stays 0; P_DATA keeps its previous value.
- Stop bit driven 0 with byte 0xFF, no parity -> STP_ERR pulses once, no DATA_VALID; a following valid frame 0x55 is received correctly.
- Start glitch (RX_IN low for 2 cycles), then idle -> FSM returns to IDLE with no strobes; single-cycle noise at OS/2 inside a data bit is outvoted by majority sampling.
- Back-to-back frames 0x12, 0x34 with no gap, then RST low mid-third-frame -> two DATA_VALID pulses with the correct values; after reset all outputs are 0 and the next frame is received normally.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver.
//   uart_state_e : receiver frame FSM state, 3-bit encoding
//   START_BIT    : line level of a start bit
//   STOP_BIT     : line level of a stop bit
//   PAR_EVEN     : PAR_TYP value selecting even parity
//   PAR_ODD      : PAR_TYP value selecting odd parity
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_rx_data_sampler.sv
// -----------------------------------------------------------------------------
// data_sampler
// Three-point majority sampler for one oversampled UART bit.
// The synchronised line is captured at edge_cnt = OS/2-1, OS/2 and OS/2+1;
// the majority of the three is the bit value.
//   i_clk           : oversampling clock
//   i_rst_n         : asynchronous active-low reset
//   i_rx_s          : synchronised serial line
//   i_edge_cnt      : position inside the current bit, 0..OVERSAMPLE-1
//   o_bit           : majority value, meaningful from edge_cnt = OS/2+2 to
//                     the end of the bit
//   o_sample_done   : high for the single cycle edge_cnt = OS/2+2, the first
//                     cycle in which o_bit reflects all three samples
// -----------------------------------------------------------------------------
module data_sampler #(
    parameter int OVERSAMPLE = 8,
    parameter int CW         = $clog2(OVERSAMPLE)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_rx_s,
    input  logic [CW-1:0] i_edge_cnt,
    output logic          o_bit,
    output logic          o_sample_done
);

    localparam logic [CW-1:0] C_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_S2   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] C_DONE = CW'(OVERSAMPLE / 2 + 2);

    logic [2:0] r_samp;

    // Samples are never cleared: each bit overwrites all three before
    // o_sample_done, so stale values from a previous bit cannot leak.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_samp <= 3'b111;
        end else begin
            if (i_edge_cnt == C_S0) r_samp[0] <= i_rx_s;
            if (i_edge_cnt == C_S1) r_samp[1] <= i_rx_s;
            if (i_edge_cnt == C_S2) r_samp[2] <= i_rx_s;
        end
    end

    assign o_bit = (r_samp[0] & r_samp[1]) |
                   (r_samp[0] & r_samp[2]) |
                   (r_samp[1] & r_samp[2]);

    assign o_sample_done = (i_edge_cnt == C_DONE);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: start bit, DATA_WIDTH data bits LSB first, optional parity
// bit, one stop bit, with OVERSAMPLE clock ticks per bit (8, 16 or 32).
//   CLK         : oversampling clock
//   RST         : asynchronous active-low reset
//   RX_IN       : serial line, idle high (asynchronous, synchronised inside)
//   PAR_EN      : 1 = frame carries a parity bit (latched at start detection)
//   PAR_TYP     : 0 = even, 1 = odd parity (latched at start detection)
//   P_DATA      : last correctly received word
//   DATA_VALID  : one-cycle pulse, P_DATA updated this cycle
//   PAR_ERR     : one-cycle pulse, parity mismatch on the frame just ended
//   STP_ERR     : one-cycle pulse, stop bit sampled low
//   o_dbg_state : current FSM state, for observation only
//
// Output protocol: DATA_VALID/PAR_ERR/STP_ERR are push-only strobes with no
// ready/back-pressure; the consumer must capture P_DATA in the strobe cycle
// or later (P_DATA holds until the next good frame).
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output uart_state_e           o_dbg_state
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] C_EDGE_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] C_EDGE_ONE  = CW'(1);
    localparam logic [CW-1:0] C_EDGE_ZERO = '0;
    localparam logic [BW-1:0] C_BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] C_BIT_ONE   = BW'(1);

    // ---------------------------------------------------------------- sync
    logic [1:0] r_sync;
    logic       w_rx_s;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RX_IN};
        end
    end

    assign w_rx_s = r_sync[1];

    // ---------------------------------------------------------- registers
    uart_state_e           r_state;
    uart_state_e           w_next_state;
    logic [CW-1:0]         r_edge_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_bad;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;

    logic w_bit;
    logic w_sample_done;
    logic w_bit_end;
    logic w_last_bit;
    logic w_start_det;
    logic w_frame_end;
    logic w_stop_ok;
    logic w_exp_par;

    data_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .CW         (CW)
    ) u_sampler (
        .i_clk         (CLK),
        .i_rst_n       (RST),
        .i_rx_s        (w_rx_s),
        .i_edge_cnt    (r_edge_cnt),
        .o_bit         (w_bit),
        .o_sample_done (w_sample_done)
    );

    assign w_bit_end   = (r_edge_cnt == C_EDGE_LAST);
    assign w_last_bit  = (r_bit_cnt == C_BIT_LAST);
    assign w_start_det = (r_state == ST_IDLE) && (w_rx_s == START_BIT);
    assign w_frame_end = (r_state == ST_STOP) && w_bit_end;
    // The sampler holds its majority until the bit ends, so the stop value
    // is still valid in the last cycle of the stop bit.
    assign w_stop_ok   = (w_bit == STOP_BIT);
    assign w_exp_par   = (^r_shift) ^ (r_par_typ == PAR_ODD);

    // --------------------------------------------------------------- FSM
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_s == START_BIT) w_next_state = ST_START;
            end
            ST_START: begin
                // A start bit that does not hold low through mid-bit is noise.
                if (w_sample_done && (w_bit != START_BIT)) begin
                    w_next_state = ST_IDLE;
                end else if (w_bit_end) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end && w_last_bit) begin
                    w_next_state = r_par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_bit_end) w_next_state = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign o_dbg_state = r_state;

    // ---------------------------------------------------------- counters
    // The IDLE cycle that detects the start bit counts as edge 0 of that
    // bit, so the counter enters START already at 1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_edge_cnt <= w_start_det ? C_EDGE_ONE : C_EDGE_ZERO;
        end else if (w_bit_end || (w_next_state == ST_IDLE)) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + C_EDGE_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bit_cnt <= '0;
        end else if (r_state != ST_DATA) begin
            r_bit_cnt <= '0;
        end else if (w_bit_end) begin
            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + C_BIT_ONE;
        end
    end

    // ------------------------------------------------ shift reg / parity
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_par_bad <= 1'b0;
        end else begin
            if (w_start_det) begin
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
                r_par_bad <= 1'b0;
            end
            // LSB arrives first: shift right so it ends up in bit 0.
            if ((r_state == ST_DATA) && w_sample_done) begin
                r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
            end
            if ((r_state == ST_PARITY) && w_sample_done) begin
                r_par_bad <= (w_bit != w_exp_par);
            end
        end
    end

    // ----------------------------------------------------------- outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            if (w_frame_end) begin
                if (!r_par_bad && w_stop_ok) begin
                    r_data_valid <= 1'b1;
                    r_p_data     <= r_shift;
                end else begin
                    r_par_err <= r_par_bad;
                    r_stp_err <= !w_stop_ok;
                end
            end
        end
    end

    assign P_DATA     = r_p_data;
    assign DATA_VALID = r_data_valid;
    assign PAR_ERR    = r_par_err;
    assign STP_ERR    = r_stp_err;

endmodule
